and_operand_sequencer: RTL and testbench
========================================

Name: and_operand_sequencer

Overview:
- Upstream stage of the and32x1x16 AND array.
- Accepts a serial stream of 32-bit operand words, each with a 1-bit enable, over a valid/ready handshake.
- Packs NUM_LANES words into one parallel frame and presents it to the array with a valid/ready handshake.
- Single frame buffer; the FSM alternates between filling the buffer and holding the frame.

Parameters:
- WIDTH, 32, bits per operand word.
- NUM_LANES, 16, words per frame; power of two, at least 2.
- CNT_W, $clog2(NUM_LANES)+1, width of the lane count; derived, not overridden.

Ports:
- C  input  1  clock; all state updates on posedge.
- RN  input  1  reset; synchronous, active-low.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  sequencer can accept a word.
- in_data  input  WIDTH  operand word.
- in_en  input  1  per-word enable bit; drives the array's 1-bit operand.
- flush  input  1  close a partial frame early.
- out_valid  output  1  frame valid.
- out_ready  input  1  array consumes the frame.
- out_a  output  NUM_LANES*WIDTH  packed words; lane k is bits [k*WIDTH +: WIDTH].
- out_b  output  NUM_LANES  enable bits; bit k belongs to lane k.
- out_count  output  CNT_W  number of lanes loaded in the frame (1..NUM_LANES).

Behaviour:
- States: FILL, HOLD. Reset (RN=0 at posedge) forces:
  - state FILL, lane index 0;
  - out_a 0, out_b 0, out_count 0, out_valid 0.
  - Reset mid-frame discards the partial frame with no output.
- in_ready = (state==FILL); out_valid = (state==HOLD). Both are purely state-decoded, with no combinational path from any input.
- Accept = in_valid & in_ready. On accept:
  - lane[idx] <= in_data; out_b[idx] <= in_en; idx++.
  - out_count tracks idx+1.
- FILL -> HOLD when either:
  - a word is accepted with idx==NUM_LANES-1 (frame full; idx wraps to 0), or
  - flush=1 while idx>0, or flush=1 coincident with an accept; that accepted word is stored first.
- flush with idx==0 and no accept is ignored. flush in HOLD is ignored.
- HOLD:
  - out_a, out_b and out_count are held stable.
  - in_valid is not accepted.
  - On out_ready=1: go to FILL; clear out_a, out_b, out_count and idx.
  - Cleared lanes guarantee that a partial frame's unloaded lanes read data 0, enable 0.
- Latency: the frame is visible the cycle after its last accept (or after the flush cycle).
- Throughput: at most NUM_LANES words per NUM_LANES+1 cycles. The handoff cycle is the single bubble.
- out_ready while in FILL has no effect.
- Unused upper lanes are zero; the array must gate on out_b.

Optional Feature:
- Macro: AND_SEQ_PARITY_EN.
- Defined:
  - Adds output out_par, NUM_LANES bits.
  - out_par[k] = even parity of the lane-k word, registered alongside the data.
  - Parity is 0 for empty lanes and 0 at reset.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package and_seq_pkg holds:
  - WIDTH and NUM_LANES defaults;
  - state enum {FILL, HOLD};
  - a lane index typedef of $clog2(NUM_LANES) bits;
  - a count typedef of CNT_W bits.
- One natural sub-module: and_seq_lane. It is a single-lane register (data, en, optional parity) with write-enable and clear, instantiated NUM_LANES times via generate.
- The FSM and index counter stay in the top module.

Test Plan:
- Reset: hold RN=0 for 3 cycles, then release → in_ready=1, out_valid=0, out_a=0, out_count=0.
- Full frame: 16 back-to-back words 0x00000001..0x00000010 with in_en alternating 1,0 → the cycle after the 16th accept:
  - out_valid=1, out_count=16;
  - lane 0 = 0x1, lane 15 = 0x10;
  - out_b=16'h5555;
  - in_ready=0.
- Backpressure: keep out_ready=0 for 10 cycles in HOLD while in_valid=1 → frame stable, no words accepted. Then out_ready=1 for 1 cycle → next cycle in_ready=1, out_a=0.
- Partial flush: load 3 words 0xDEADBEEF, 0x12345678, 0xFFFFFFFF with en=1, asserting flush on the 3rd accept → out_count=3, out_b=16'h0007, lanes 3..15 = 0.
- Edge cases:
  - flush at idx=0 with in_valid=0 → stays in FILL, out_valid=0.
  - RN=0 asserted after 7 words accepted → idx=0 and no frame emitted; the next 16 words form a clean frame.
- With AND_SEQ_PARITY_EN: words 0x00000003 and 0x00000007 → out_par[0]=0, out_par[1]=1.

Source files
------------

// File: rtl/and_seq_pkg.sv
// and_seq_pkg: shared defaults, FSM state and index/count types for the AND operand sequencer
package and_seq_pkg;
   localparam int WIDTH     = 32;
   localparam int NUM_LANES = 16;
   localparam int IDX_W     = $clog2(NUM_LANES);
   localparam int CNT_W     = $clog2(NUM_LANES) + 1;
   typedef enum logic {FILL, HOLD} state_t;
   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/and_seq_lane.sv
// and_seq_lane: one frame lane register (word, enable, parity when AND_SEQ_PARITY_EN is defined)
module and_seq_lane #(
   parameter int WIDTH = 32
) (
   input  logic             C,
   input  logic             RN,
   input  logic             we,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic             q_en
`ifdef AND_SEQ_PARITY_EN
   ,
   output logic             q_par
`endif
);
   // load the word on write; reset and frame release zero the lane
   always_ff @(posedge C) begin
      if (!RN || clr) begin
         q    <= '0;
         q_en <= 1'b0;
      end else if (we) begin
         q    <= d;
         q_en <= en;
      end
   end
`ifdef AND_SEQ_PARITY_EN
   // even parity stored alongside the word so it stays aligned with the data
   always_ff @(posedge C) begin
      if (!RN || clr) q_par <= 1'b0;
      else if (we) q_par <= ^d;
   end
`endif
endmodule

// File: rtl/and_operand_sequencer.sv
// and_operand_sequencer: packs serial operand words into one NUM_LANES-wide frame; AND_SEQ_PARITY_EN adds out_par
module and_operand_sequencer
   import and_seq_pkg::*;
#(
   parameter int WIDTH     = and_seq_pkg::WIDTH,
   parameter int NUM_LANES = and_seq_pkg::NUM_LANES,
   localparam int CNT_W    = $clog2(NUM_LANES) + 1
) (
   input  logic                       C,
   input  logic                       RN,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_en,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_LANES*WIDTH-1:0] out_a,
   output logic [NUM_LANES-1:0]       out_b,
   output logic [CNT_W-1:0]           out_count
`ifdef AND_SEQ_PARITY_EN
   ,
   output logic [NUM_LANES-1:0]       out_par
`endif
);
   localparam int IW = $clog2(NUM_LANES);
   state_t        state, state_nx;
   logic [IW-1:0] idx;
   logic          accept, close, clr;
   assign accept = in_valid & in_ready;
   assign clr    = (state == HOLD) & out_ready;
   assign close  = (accept & (idx == IW'(NUM_LANES - 1))) | (flush & (state == FILL) & ((idx != '0) | accept));
   // state register
   always_ff @(posedge C) begin
      if (!RN) state <= FILL;
      else state <= state_nx;
   end
   // next state: close the frame while filling, release it on out_ready
   always_comb begin
      state_nx = (state == FILL) ? (close ? HOLD : FILL) : (out_ready ? FILL : HOLD);
   end
   // handshake outputs decoded from state only
   always_comb begin
      in_ready  = (state == FILL);
      out_valid = (state == HOLD);
   end
   // lane index wraps naturally on a full frame; count runs one ahead of the index
   always_ff @(posedge C) begin
      if (!RN || clr) begin
         idx       <= '0;
         out_count <= '0;
      end else if (accept) begin
         idx       <= idx + 1'b1;
         out_count <= CNT_W'(idx) + 1'b1;
      end
   end
   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      and_seq_lane #(.WIDTH(WIDTH)) u_lane (
         .C    (C),
         .RN   (RN),
         .we   (accept & (idx == IW'(k))),
         .clr  (clr),
         .d    (in_data),
         .en   (in_en),
         .q    (out_a[k*WIDTH +: WIDTH]),
         .q_en (out_b[k])
`ifdef AND_SEQ_PARITY_EN
         ,
         .q_par(out_par[k])
`endif
      );
   end
endmodule

// File: tb/tb_and_operand_sequencer.sv
// tb_and_operand_sequencer: directed table, hand sequences and random traffic against a frame-level model
module tb_and_operand_sequencer;
   localparam int W  = 32;
   localparam int N  = 16;
   localparam int CW = 5;

   logic          C = 1'b0, RN = 1'b0, in_valid = 1'b0, in_en = 1'b0, flush = 1'b0, out_ready = 1'b0;
   logic [W-1:0]  in_data = '0;
   logic          in_ready, out_valid;
   logic [N*W-1:0] out_a;
   logic [N-1:0]  out_b;
   logic [CW-1:0] out_count;
`ifdef AND_SEQ_PARITY_EN
   logic [N-1:0]  out_par;
`endif

   and_operand_sequencer dut (
      .C(C), .RN(RN), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_en(in_en),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .out_count(out_count)
`ifdef AND_SEQ_PARITY_EN
      , .out_par(out_par)
`endif
   );

   always #5 C = ~C;

   int n_cmp = 0, n_bad = 0;

   // frame-level reference: words collected so far and whether the frame is being held
   logic [W-1:0] m_a[N];
   logic [N-1:0] m_b;
   int           m_n;
   bit           m_hold;

   task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic m_clear();
      for (int k = 0; k < N; k++) m_a[k] = '0;
      m_b = '0;
      m_n = 0;
      m_hold = 0;
   endtask

   task automatic m_step();
      if (!RN) m_clear();
      else if (m_hold) begin
         if (out_ready) m_clear();
      end else if (in_valid) begin
         m_a[m_n] = in_data;
         m_b[m_n] = in_en;
         m_n++;
         if (m_n == N || flush) m_hold = 1;
      end else if (flush && m_n > 0) m_hold = 1;
   endtask

   task automatic m_check();
      logic [N*W-1:0] ea;
      logic [N-1:0]   ep;
      for (int k = 0; k < N; k++) begin
         ea[k*W +: W] = m_a[k];
         ep[k] = ^m_a[k];
      end
      chk("in_ready", in_ready, !m_hold);
      chk("out_valid", out_valid, m_hold);
      chk("out_a", out_a, ea);
      chk("out_b", out_b, m_b);
      chk("out_count", out_count, m_n);
`ifdef AND_SEQ_PARITY_EN
      chk("out_par", out_par, ep);
`else
      if (ep === 'x) $display("parity model unknown");
`endif
   endtask

   task automatic cycle();
      m_step();
      @(posedge C);
      #1;
      m_check();
   endtask

   task automatic put(input logic [W-1:0] d, input logic e, input logic f);
      in_valid = 1'b1;
      in_data  = d;
      in_en    = e;
      flush    = f;
      cycle();
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   typedef struct {
      logic        rn, v;
      logic [31:0] d;
      logic        en, fl, rdy;
      logic        e_ir, e_ov;
      logic [4:0]  e_cnt;
      logic [15:0] e_b;
   } vec_t;

   vec_t tbl[10];
   logic [N*W-1:0] snap;

   initial begin
      m_clear();
      tbl[0] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 16'h0000};
      tbl[1] = '{1'b0, 1'b1, 32'h5,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 16'h0000};
      tbl[2] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 16'h0000};
      tbl[3] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 16'h0000};
      tbl[4] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 16'h0001};
      tbl[5] = '{1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 16'h0003};
      tbl[6] = '{1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 16'h0007};
      tbl[7] = '{1'b1, 1'b1, 32'hAAAA5555, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 16'h0007};
      tbl[8] = '{1'b1, 1'b1, 32'h11111111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 16'h0000};
      tbl[9] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 16'h0000};
      foreach (tbl[i]) begin
         RN = tbl[i].rn; in_valid = tbl[i].v; in_data = tbl[i].d;
         in_en = tbl[i].en; flush = tbl[i].fl; out_ready = tbl[i].rdy;
         cycle();
         chk($sformatf("vec%0d.in_ready", i), in_ready, tbl[i].e_ir);
         chk($sformatf("vec%0d.out_valid", i), out_valid, tbl[i].e_ov);
         chk($sformatf("vec%0d.out_count", i), out_count, tbl[i].e_cnt);
         chk($sformatf("vec%0d.out_b", i), out_b, tbl[i].e_b);
         if (i == 6) begin
            chk("partial.lane0", out_a[31:0], 32'hDEADBEEF);
            chk("partial.lane2", out_a[95:64], 32'hFFFFFFFF);
            chk("partial.upper_zero", out_a[N*W-1:96], '0);
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;

      for (int i = 0; i < N; i++) put(W'(i + 1), (i % 2) == 0, 1'b0);
      chk("full.out_valid", out_valid, 1'b1);
      chk("full.in_ready", in_ready, 1'b0);
      chk("full.count", out_count, 5'd16);
      chk("full.lane0", out_a[31:0], 32'h1);
      chk("full.lane15", out_a[15*W +: W], 32'h10);
      chk("full.out_b", out_b, 16'h5555);
      snap = out_a;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = $urandom;
         in_en   = 1'($urandom);
         cycle();
         chk("backpressure.stable", out_a, snap);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      chk("release.in_ready", in_ready, 1'b1);
      chk("release.out_a", out_a, '0);

      for (int i = 0; i < 7; i++) put($urandom, 1'b1, 1'b0);
      RN = 1'b0;
      cycle();
      RN = 1'b1;
      chk("midreset.out_valid", out_valid, 1'b0);
      chk("midreset.count", out_count, 5'd0);
      for (int i = 0; i < N; i++) put(32'hC000_0000 | W'(i), 1'b1, 1'b0);
      chk("clean.count", out_count, 5'd16);
      chk("clean.lane0", out_a[31:0], 32'hC0000000);
      chk("clean.lane6", out_a[6*W +: W], 32'hC0000006);
      chk("clean.out_b", out_b, 16'hFFFF);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;

`ifdef AND_SEQ_PARITY_EN
      put(32'h3, 1'b1, 1'b0);
      put(32'h7, 1'b1, 1'b1);
      chk("parity.lanes", out_par[1:0], 2'b10);
      chk("parity.empty", out_par[N-1:2], '0);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
`endif

      for (int i = 0; i < 2000; i++) begin
         RN        = ($urandom_range(0, 49) != 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = $urandom;
         in_en     = 1'($urandom);
         flush     = ($urandom_range(0, 9) == 0);
         out_ready = ($urandom_range(0, 9) < 4);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
